// File: rtl/neuromorphic_x1_pkg.sv
// -----------------------------------------------------------------------------
// neuromorphic_x1_pkg
// Shared definitions for the NEUROMORPHIC_X1 Wishbone bridge:
//   - bus and select widths
//   - default address-window constants
//   - bridge FSM state encoding
//   - address-window hit helper
// Optional feature macro used by the bridge: NEUROMORPHIC_X1_TIMEOUT_EN
// -----------------------------------------------------------------------------
package neuromorphic_x1_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'h3000_0000;
    localparam logic [DATA_W-1:0] DEFAULT_ADDR_MASK = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the masked byte address falls in the window starting at base.
    function automatic logic addr_hit(
        input logic [DATA_W-1:0] adr,
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] mask
    );
        return ((adr & mask) == base);
    endfunction

endpackage

// File: rtl/neuromorphic_x1_watchdog.sv
// -----------------------------------------------------------------------------
// neuromorphic_x1_watchdog
// Cycle counter that flags expiry once it has been enabled for LIMIT cycles
// since the last clear. The expire flag is registered and is high during the
// LIMIT-th enabled cycle, so the owner can act on it at the end of that cycle.
// Only instantiated when NEUROMORPHIC_X1_TIMEOUT_EN is defined.
//
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_clear   restart counting (takes priority over enable)
//   i_enable  count this cycle
//   o_expire  registered expiry flag
// -----------------------------------------------------------------------------
module neuromorphic_x1_watchdog
    import neuromorphic_x1_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + CW'(1);

    // Count enabled cycles; expiry is pre-computed one cycle ahead so the
    // flag is already high during the LIMIT-th enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            o_expire <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            o_expire <= 1'b0;
        end else if (i_enable) begin
            r_cnt    <= w_cnt_next;
            o_expire <= (w_cnt_next == CW'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/neuromorphic_x1_wb_bridge.sv
// -----------------------------------------------------------------------------
// neuromorphic_x1_wb_bridge
// Wishbone-classic slave that turns bus cycles hitting an address window into
// single-outstanding EN / func_ack handshakes with the NEUROMORPHIC_X1 macro.
//
// Optional feature macro: NEUROMORPHIC_X1_TIMEOUT_EN
//   defined   : a watchdog ends REQ after TIMEOUT_CYCLES and answers with err
//   undefined : REQ waits for func_ack indefinitely, wbs_err_o is constant 0
//
// Ports:
//   CLKin, RSTin              clock, synchronous active-high reset
//   wbs_cyc_i .. wbs_dat_i    Wishbone request from the bus master
//   wbs_ack_o, wbs_err_o      one-cycle transfer termination
//   wbs_dat_o                 last read data (held across writes)
//   EN, R_WB, DI, AD, SEL     request to the macro, held stable during REQ
//   DO, func_ack              macro read data and completion pulse
//   busy                      high while a transfer is in REQ or RESP
// -----------------------------------------------------------------------------
module neuromorphic_x1_wb_bridge
    import neuromorphic_x1_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter logic [DATA_W-1:0] ADDR_MASK      = DEFAULT_ADDR_MASK,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              CLKin,
    input  logic              RSTin,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [SEL_W-1:0]  wbs_sel_i,
    input  logic [DATA_W-1:0] wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic              EN,
    output logic              R_WB,
    output logic [DATA_W-1:0] DI,
    output logic [DATA_W-1:0] AD,
    output logic [SEL_W-1:0]  SEL,
    input  logic [DATA_W-1:0] DO,
    input  logic              func_ack,
    output logic              busy
);

    state_t r_state;
    logic   r_abort;
    logic   w_accept;
    logic   w_aborted;
    logic   w_expire;

    assign w_accept  = (r_state == ST_IDLE) & wbs_cyc_i & wbs_stb_i
                     & addr_hit(wbs_adr_i, BASE_ADDR, ADDR_MASK);

    // The master may drop cyc in the very cycle func_ack arrives; that still
    // counts as an abort, so the registered flag is combined with the live pin.
    assign w_aborted = r_abort | ~wbs_cyc_i;

`ifdef NEUROMORPHIC_X1_TIMEOUT_EN
    neuromorphic_x1_watchdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (CLKin),
        .i_rst    (RSTin),
        .i_clear  (w_accept),
        .i_enable (r_state == ST_REQ),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Bridge FSM with all bus and macro outputs registered.
    always_ff @(posedge CLKin) begin
        if (RSTin) begin
            r_state   <= ST_IDLE;
            r_abort   <= 1'b0;
            EN        <= 1'b0;
            R_WB      <= 1'b1;
            DI        <= '0;
            AD        <= '0;
            SEL       <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    wbs_ack_o <= 1'b0;
                    wbs_err_o <= 1'b0;
                    if (w_accept) begin
                        EN      <= 1'b1;
                        R_WB    <= ~wbs_we_i;
                        DI      <= wbs_dat_i;
                        AD      <= wbs_adr_i & ~ADDR_MASK;
                        SEL     <= wbs_sel_i;
                        r_abort <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!wbs_cyc_i) begin
                        r_abort <= 1'b1;
                    end
                    // func_ack beats a watchdog expiry in the same cycle.
                    if (func_ack) begin
                        EN        <= 1'b0;
                        if (R_WB) begin
                            wbs_dat_o <= DO;
                        end
                        wbs_ack_o <= ~w_aborted;
                        r_state   <= ST_RESP;
                    end else if (w_expire) begin
                        EN        <= 1'b0;
                        wbs_err_o <= ~w_aborted;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    wbs_ack_o <= 1'b0;
                    wbs_err_o <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    EN        <= 1'b0;
                    wbs_ack_o <= 1'b0;
                    wbs_err_o <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
